// File: rtl/complex_unit_pkg.sv
// Shared types for the RV32M complex unit: funct3 op codes, FSM states, divider depth.
// Signedness helpers decide operand sign-extension for both the multiplier and the divider.
package complex_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } cu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } cu_state_e;

    localparam int DIV_ITERS = 32;

    function automatic logic is_signed_rs1(input cu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_rs2(input cu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/complex_unit_if.sv
// Complex-op port between the memory scheduler (master) and the RV32M unit (slave).
// One-cycle request strobe while !busy_o; one-cycle wb_valid_o completion pulse.
interface complex_unit_if;
    logic        cu_valid_i;
    logic [2:0]  cu_opcode_i;
    logic [31:0] cu_operand1_i;
    logic [31:0] cu_operand2_i;
    logic        busy_o;
    logic [31:0] result_o;
    logic        wb_valid_o;

    modport master (
        output cu_valid_i, cu_opcode_i, cu_operand1_i, cu_operand2_i,
        input  busy_o, result_o, wb_valid_o
    );

    modport slave (
        input  cu_valid_i, cu_opcode_i, cu_operand1_i, cu_operand2_i,
        output busy_o, result_o, wb_valid_o
    );
endinterface

// File: rtl/complex_unit_divider_core.sv
// Restoring radix-2 unsigned divider: one quotient bit per edge, done DIV_ITERS edges after start.
// No backpressure: done_o is held until the next edge, abort_i drops the op immediately.
module cu_divider_core
    import complex_pkg::*;
(
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic [5:0]  cnt_q;
    logic        active_q;
    logic [31:0] divisor_q;
    logic [63:0] sr_q;
    logic [63:0] sr_d;
    logic [32:0] partial;
    logic [32:0] diff;

    // Upper half is the running remainder, lower half shifts dividend bits out and quotient bits in.
    always_comb begin
        partial = sr_q[63:31];
        diff    = partial - {1'b0, divisor_q};
        sr_d    = diff[32] ? {partial[31:0], sr_q[30:0], 1'b0}
                           : {diff[31:0],    sr_q[30:0], 1'b1};
    end

    assign done_o = active_q && (cnt_q == 6'(DIV_ITERS));
    assign quot_o = sr_q[31:0];
    assign rem_o  = sr_q[63:32];

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q     <= '0;
            active_q  <= 1'b0;
            divisor_q <= '0;
            sr_q      <= '0;
        end else if (abort_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            cnt_q     <= '0;
            active_q  <= 1'b1;
            divisor_q <= divisor_i;
            sr_q      <= {32'd0, dividend_i};
        end else if (done_o) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (active_q) begin
            cnt_q <= cnt_q + 6'd1;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/complex_unit.sv
// RV32M multiply/divide unit: MUL ops in MUL_LATENCY cycles, DIV ops in 33 (divide-by-zero/overflow in 1).
// No backpressure: one op in flight, busy_o stalls issue, wb_valid_o is a single-cycle pulse.
module complex_unit
    import complex_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic           cpu_clk_i,
    input  logic           cpu_resetn_i,
    input  logic           flush_i,
    complex_unit_if.slave  cu
);

    localparam int PIPE_N = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
    localparam int TAP    = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

    cu_state_e   state_q;
    cu_op_e      op_q;
    logic [31:0] a_q, b_q;
    logic        neg_quot_q, neg_rem_q;
    logic        special_q;
    logic [31:0] spec_res_q;
    logic [2:0]  mul_cnt_q;
    logic        busy_q, wb_valid_q;
    logic [31:0] result_q;
    logic [63:0] mul_pipe_q [PIPE_N];

    cu_op_e      op_in;
    logic        accept;
    logic        s1_in, s2_in;
    logic [31:0] mag1, mag2;
    logic        div_by_zero, div_ovf, special_d;
    logic [31:0] spec_res_d;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quot, div_rem;
    logic [31:0] q_fix, r_fix, div_res;
    logic [63:0] mul_a, mul_b, product_d, mul_tap;
    logic [31:0] mul_res;

    always_comb begin
        op_in       = cu_op_e'(cu.cu_opcode_i);
        accept      = (state_q == ST_IDLE) && cu.cu_valid_i && !flush_i;
        s1_in       = is_signed_rs1(op_in) & cu.cu_operand1_i[31];
        s2_in       = is_signed_rs2(op_in) & cu.cu_operand2_i[31];
        mag1        = s1_in ? (32'd0 - cu.cu_operand1_i) : cu.cu_operand1_i;
        mag2        = s2_in ? (32'd0 - cu.cu_operand2_i) : cu.cu_operand2_i;
        div_by_zero = (cu.cu_operand2_i == 32'd0);
        div_ovf     = (op_in == OP_DIV || op_in == OP_REM)
                      && (cu.cu_operand1_i == 32'h8000_0000)
                      && (cu.cu_operand2_i == 32'hFFFF_FFFF);
        special_d   = div_by_zero | div_ovf;
        // REM/REMU pick the remainder (funct3 bit 1), DIV/DIVU the quotient.
        if (op_in[1])
            spec_res_d = div_by_zero ? cu.cu_operand1_i : 32'd0;
        else
            spec_res_d = div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        div_start   = accept && op_in[2] && !special_d;
    end

    cu_divider_core u_div (
        .clk_i      (cpu_clk_i),
        .resetn_i   (cpu_resetn_i),
        .start_i    (div_start),
        .abort_i    (flush_i),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    always_comb begin
        q_fix   = neg_quot_q ? (32'd0 - div_quot) : div_quot;
        r_fix   = neg_rem_q  ? (32'd0 - div_rem)  : div_rem;
        div_res = op_q[1] ? r_fix : q_fix;
    end

    // 33x33 signed product reduced mod 2^64: sign-extending to 64 bits keeps the low 64 bits exact.
    always_comb begin
        mul_a     = {{32{is_signed_rs1(op_q) & a_q[31]}}, a_q};
        mul_b     = {{32{is_signed_rs2(op_q) & b_q[31]}}, b_q};
        product_d = mul_a * mul_b;
        mul_tap   = (MUL_LATENCY == 1) ? product_d : mul_pipe_q[TAP];
        mul_res   = (op_q == OP_MUL) ? mul_tap[31:0] : mul_tap[63:32];
    end

    always_ff @(posedge cpu_clk_i) begin
        if (!cpu_resetn_i) begin
            for (int i = 0; i < PIPE_N; i++) mul_pipe_q[i] <= '0;
        end else begin
            mul_pipe_q[0] <= product_d;
            for (int i = 1; i < PIPE_N; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (!cpu_resetn_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MUL;
            a_q        <= '0;
            b_q        <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            mul_cnt_q  <= '0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            result_q   <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            if (flush_i) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                mul_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cu.cu_valid_i) begin
                            op_q       <= op_in;
                            a_q        <= cu.cu_operand1_i;
                            b_q        <= cu.cu_operand2_i;
                            neg_quot_q <= s1_in ^ s2_in;
                            neg_rem_q  <= s1_in;
                            special_q  <= special_d;
                            spec_res_q <= spec_res_d;
                            mul_cnt_q  <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= op_in[2] ? ST_DIV : ST_MUL;
                        end
                    end
                    ST_MUL: begin
                        if (mul_cnt_q == 3'(MUL_LATENCY - 1)) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            result_q   <= mul_res;
                        end else begin
                            mul_cnt_q <= mul_cnt_q + 3'd1;
                        end
                    end
                    ST_DIV: begin
                        if (special_q) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            result_q   <= spec_res_q;
                        end else if (div_done) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            result_q   <= div_res;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cu.busy_o     = busy_q;
    assign cu.wb_valid_o = wb_valid_q;
    assign cu.result_o   = result_q;

endmodule
